// File: rtl/prf_multiport.sv
// prf_multiport: multi-ported physical register file with per-register ready bits and write bypass
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   rd_addr/rd_data      NUM_RD combinational read ports, packed per port
//   rd_ready             ready bit of each addressed register
//   wr_en/wr_addr/wr_data NUM_WR write ports, written at the rising edge
//   alloc_en/alloc_addr  clears the ready bit of a newly renamed register
//   flush_en             sets every ready bit
//   wr_conflict          one-cycle flag after two write ports hit the same nonzero register
module prf_multiport #(
    parameter int WIDTH     = 32,
    parameter int NUM_PREGS = 64,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(NUM_PREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]  wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic                     flush_en,
    output logic                     wr_conflict
);
    logic [WIDTH-1:0]     r_data [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_ready;
    logic                 r_conflict;
    logic                 w_conflict;

    always_comb begin
        w_conflict = 1'b0;
        for (int a = 0; a < NUM_WR; a++)
            for (int b = a + 1; b < NUM_WR; b++)
                if (wr_en[a] && wr_en[b] && wr_addr[a*AW +: AW] == wr_addr[b*AW +: AW] && wr_addr[a*AW +: AW] != '0)
                    w_conflict = 1'b1;
    end

    // Later assignments win: ascending write ports give highest-port data priority,
    // then allocate and flush override the write's ready set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PREGS; p++) r_data[p] <= '0;
            r_ready    <= '1;
            r_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                    r_data[wr_addr[j*AW +: AW]]  <= wr_data[j*WIDTH +: WIDTH];
                    r_ready[wr_addr[j*AW +: AW]] <= 1'b1;
                end
            if (alloc_en && alloc_addr != '0) r_ready[alloc_addr] <= 1'b0;
            if (flush_en) r_ready <= '1;
            r_conflict <= w_conflict;
        end
    end

    assign wr_conflict = r_conflict;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    w_a;
        logic [WIDTH-1:0] w_d;
        logic             w_hit;
        assign w_a = rd_addr[i*AW +: AW];
        always_comb begin
            w_d   = r_data[w_a];
            w_hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++)
                if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == w_a) begin
                    w_d   = wr_data[j*WIDTH +: WIDTH];
                    w_hit = 1'b1;
                end
        end
        assign rd_data[i*WIDTH +: WIDTH] = (w_a == '0) ? '0 : w_d;
        assign rd_ready[i]               = (w_a == '0) | w_hit | r_ready[w_a];
    end
endmodule

// File: tb/tb_prf_multiport.sv
// tb_prf_multiport: checks bypassing and non-bypassing register files against a behavioural model
module tb_prf_multiport;
    logic         clk = 1'b0;
    logic         rst;
    logic [23:0]  rd_addr;
    logic [127:0] rd_data_b, rd_data_n;
    logic [3:0]   rd_ready_b, rd_ready_n;
    logic [1:0]   wr_en;
    logic [11:0]  wr_addr;
    logic [63:0]  wr_data;
    logic         alloc_en;
    logic [5:0]   alloc_addr;
    logic         flush_en;
    logic         conf_b, conf_n;

    int n_cmp = 0;
    int n_bad = 0;

    prf_multiport #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush_en(flush_en), .wr_conflict(conf_b));

    prf_multiport #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_ready(rd_ready_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush_en(flush_en), .wr_conflict(conf_n));

    always #5 clk = ~clk;

    // Behavioural model: architectural contents, ready bits and the conflict flag.
    logic [31:0] m_data [64];
    logic        m_ready [64];
    logic        m_conf;
    bit          chk_on = 0;
    int          nw;
    bit          c;

    function automatic logic [5:0] wa(input int j);
        return wr_addr[j*6 +: 6];
    endfunction

    function automatic logic [31:0] wd(input int j);
        return wr_data[j*32 +: 32];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 64; p++) begin
                m_data[p]  = 32'd0;
                m_ready[p] = 1'b1;
            end
            m_conf = 1'b0;
            chk_on = 1;
        end else begin
            c = 0;
            for (int p = 1; p < 64; p++) begin
                nw = 0;
                for (int j = 0; j < 2; j++)
                    if (wr_en[j] && wa(j) == p[5:0]) begin
                        m_data[p] = wd(j);
                        nw++;
                    end
                if (nw > 1) c = 1;
                if (flush_en) m_ready[p] = 1'b1;
                else if (alloc_en && alloc_addr == p[5:0]) m_ready[p] = 1'b0;
                else if (nw > 0) m_ready[p] = 1'b1;
            end
            m_conf = c;
        end
    end

    task automatic exp_rd(input int bp, input logic [5:0] a, output logic [31:0] d, output logic r);
        d = m_data[a];
        r = m_ready[a];
        if (a == 6'd0) begin
            d = 32'd0;
            r = 1'b1;
        end else if (bp != 0) begin
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wa(j) == a) begin
                    d = wd(j);
                    r = 1'b1;
                end
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        er;
        if (chk_on) begin
            for (int i = 0; i < 4; i++) begin
                exp_rd(1, rd_addr[i*6 +: 6], ed, er);
                cmp($sformatf("model byp rd_data[%0d]", i), rd_data_b[i*32 +: 32], ed);
                cmp($sformatf("model byp rd_ready[%0d]", i), {31'd0, rd_ready_b[i]}, {31'd0, er});
                exp_rd(0, rd_addr[i*6 +: 6], ed, er);
                cmp($sformatf("model nob rd_data[%0d]", i), rd_data_n[i*32 +: 32], ed);
                cmp($sformatf("model nob rd_ready[%0d]", i), {31'd0, rd_ready_n[i]}, {31'd0, er});
            end
            cmp("model byp wr_conflict", {31'd0, conf_b}, {31'd0, m_conf});
            cmp("model nob wr_conflict", {31'd0, conf_n}, {31'd0, m_conf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        alloc_en = 0; alloc_addr = 0; flush_en = 0;
    endtask

    task automatic wr(input int j, input logic [5:0] a, input logic [31:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*6 +: 6] = a;
        wr_data[j*32 +: 32] = d;
    endtask

    task automatic alloc(input logic [5:0] a);
        alloc_en = 1'b1;
        alloc_addr = a;
    endtask

    task automatic rd4(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2, input logic [5:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    // Literal expectation on one read port of the bypassing (bp=1) or plain (bp=0) instance.
    task automatic lit(input string nm, input int bp, input int i, input logic [31:0] d, input logic r);
        cmp({nm, bp != 0 ? " byp data" : " nob data"}, bp != 0 ? rd_data_b[i*32 +: 32] : rd_data_n[i*32 +: 32], d);
        cmp({nm, bp != 0 ? " byp ready" : " nob ready"}, {31'd0, bp != 0 ? rd_ready_b[i] : rd_ready_n[i]}, {31'd0, r});
    endtask

    task automatic lit_conf(input string nm, input logic v);
        cmp({nm, " byp conflict"}, {31'd0, conf_b}, {31'd0, v});
        cmp({nm, " nob conflict"}, {31'd0, conf_n}, {31'd0, v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rd4(0, 0, 0, 0);
        rst = 1;
        tick(); tick();
        rst = 0;
        // Traffic before a mid-stream reset.
        wr(0, 5, 32'h11); wr(1, 9, 32'h22);
        tick(); clr();
        alloc(7);
        tick(); clr();
        rd4(5, 9, 7, 0);
        rst = 1; wr(0, 5, 32'h33); wr(1, 5, 32'h44); alloc(9); flush_en = 1;
        tick(); clr();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            lit("reset", 1, i, 32'd0, 1'b1);
            lit("reset", 0, i, 32'd0, 1'b1);
        end
        lit_conf("reset", 1'b0);
        tick();
        // Write p5 via port 1, same-cycle read on every port.
        rd4(5, 5, 5, 5);
        wr(1, 5, 32'hDEADBEEF);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            lit("wr same-cycle", 1, i, 32'hDEADBEEF, 1'b1);
            lit("wr same-cycle", 0, i, 32'd0, 1'b1);
        end
        tick(); clr();
        @(negedge clk);
        lit("wr next-cycle", 1, 0, 32'hDEADBEEF, 1'b1);
        lit("wr next-cycle", 0, 3, 32'hDEADBEEF, 1'b1);
        tick();
        // Register 0 ignores writes and allocation.
        rd4(0, 0, 0, 0);
        wr(0, 0, 32'h1234); wr(1, 0, 32'h1234); alloc(0);
        @(negedge clk);
        lit("p0 same-cycle", 1, 0, 32'd0, 1'b1);
        lit("p0 same-cycle", 0, 1, 32'd0, 1'b1);
        tick(); clr();
        @(negedge clk);
        lit("p0 after", 1, 2, 32'd0, 1'b1);
        lit_conf("p0", 1'b0);
        tick();
        // Two ports writing p9.
        rd4(9, 9, 9, 9);
        wr(0, 9, 32'hAAAA); wr(1, 9, 32'hBBBB);
        @(negedge clk);
        lit("conflict fwd", 1, 0, 32'hBBBB, 1'b1);
        lit_conf("conflict pre", 1'b0);
        tick(); clr();
        @(negedge clk);
        lit_conf("conflict", 1'b1);
        lit("conflict data", 1, 1, 32'hBBBB, 1'b1);
        lit("conflict data", 0, 2, 32'hBBBB, 1'b1);
        tick();
        @(negedge clk);
        lit_conf("conflict drop", 1'b0);
        tick();
        // Ready lifecycle on p12.
        rd4(12, 12, 12, 12);
        alloc(12);
        tick(); clr();
        @(negedge clk);
        lit("alloc", 1, 0, 32'd0, 1'b0);
        lit("alloc", 0, 0, 32'd0, 1'b0);
        tick();
        wr(0, 12, 32'd7);
        @(negedge clk);
        lit("wb same-cycle", 1, 1, 32'd7, 1'b1);
        lit("wb same-cycle", 0, 1, 32'd0, 1'b0);
        tick(); clr();
        @(negedge clk);
        lit("wb", 1, 2, 32'd7, 1'b1);
        lit("wb", 0, 2, 32'd7, 1'b1);
        tick();
        alloc(12); wr(1, 12, 32'd8);
        tick(); clr();
        @(negedge clk);
        lit("alloc+wr", 1, 3, 32'd8, 1'b0);
        lit("alloc+wr", 0, 3, 32'd8, 1'b0);
        tick();
        // Flush overrides a same-cycle allocate.
        rd4(3, 4, 5, 6);
        alloc(3); tick();
        alloc(4); tick();
        alloc(5); tick(); clr();
        @(negedge clk);
        lit("pre-flush p5", 0, 2, 32'hDEADBEEF, 1'b0);
        tick();
        flush_en = 1; alloc(6);
        tick(); clr();
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            lit("flush p3", b, 0, 32'd0, 1'b1);
            lit("flush p4", b, 1, 32'd0, 1'b1);
            lit("flush p5", b, 2, 32'hDEADBEEF, 1'b1);
            lit("flush p6", b, 3, 32'd0, 1'b1);
        end
        tick();
        // Mixed traffic for the model compare: flush with writes, alloc+write on distinct ports.
        rd4(20, 21, 12, 9);
        wr(0, 20, 32'h5555); wr(1, 21, 32'h6666); alloc(21);
        tick(); clr();
        wr(0, 9, 32'h77); flush_en = 1; alloc(20);
        tick(); clr();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
